// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame constants,
// scan-code values used by the downstream displays, and a parity helper.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic PS2_START_BIT = 1'b0;
   localparam logic PS2_STOP_BIT  = 1'b1;
   localparam int   PS2_DATA_BITS = 8;

   // Scan-code prefixes shared by the seven-segment and VGA keyboard views.
   localparam logic [7:0] BREAK  = 8'hF0;
   localparam logic [7:0] EXTEND = 8'hE0;

   // A PS/2 frame is good when data plus parity bit holds an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pin: 2-FF synchronizer, optional run-length glitch
// filter, and a registered one-cycle strobe on each filtered 1->0 transition.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter bit FILTER_EN  = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pin,
   output logic o_level,
   output logic o_fall
);

   logic sync1_r;
   logic sync2_r;

   // Two-stage synchronizer; the PS/2 lines idle high, so reset to 1.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= i_pin;
         sync2_r <= sync1_r;
      end
   end

   generate
      if (FILTER_EN) begin : g_filter
         localparam int CW = $clog2(FILTER_LEN + 1);
         localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

         logic          level_r;
         logic [CW-1:0] cnt_r;
         logic          fall_r;

         // Level flips only after FILTER_LEN consecutive disagreeing samples;
         // any agreeing sample restarts the run.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               level_r <= 1'b1;
               cnt_r   <= {CW{1'b0}};
               fall_r  <= 1'b0;
            end else if (sync2_r == level_r) begin
               cnt_r  <= {CW{1'b0}};
               fall_r <= 1'b0;
            end else if (cnt_r == CNT_LAST) begin
               level_r <= sync2_r;
               cnt_r   <= {CW{1'b0}};
               fall_r  <= ~sync2_r;
            end else begin
               cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               fall_r <= 1'b0;
            end
         end

         assign o_level = level_r;
         assign o_fall  = fall_r;
      end else begin : g_bypass
         logic prev_r;
         logic fall_r;

         // Unfiltered path: edge strobe taken straight from the synchronizer.
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               prev_r <= 1'b1;
               fall_r <= 1'b0;
            end else begin
               prev_r <= sync2_r;
               fall_r <= prev_r & ~sync2_r;
            end
         end

         assign o_level = sync2_r;
         assign o_fall  = fall_r;
      end
   endgenerate

endmodule

// File: rtl/ps2_frame_receiver.sv
// Device-to-host PS/2 frame receiver. Checks start/odd-parity/stop, aborts
// stalled frames on timeout, and shifts good bytes into a 3-byte history.
module ps2_frame_receiver
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ_HZ    = 50000000,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_PS2C,
   input  logic        i_PS2D,
   output logic [23:0] o_Data,
   output logic [7:0]  o_Byte,
   output logic        o_Valid,
   output logic        o_ParityErr,
   output logic        o_FrameErr,
   output logic        o_Busy
);

   // The timeout length is expressed in system clocks, so the clock rate only
   // matters through TIMEOUT_CYCLES; a non-positive rate degenerates to 1 bit.
   localparam int TW = (CLK_FREQ_HZ > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic sample_s;
   logic c_level_unused_s;
   logic d_level_s;
   logic d_fall_unused_s;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN),
      .FILTER_EN  (1'b1)
   ) u_clk_filter (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_pin   (i_PS2C),
      .o_level (c_level_unused_s),
      .o_fall  (sample_s)
   );

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN),
      .FILTER_EN  (1'b0)
   ) u_data_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_pin   (i_PS2D),
      .o_level (d_level_s),
      .o_fall  (d_fall_unused_s)
   );

   ps2_state_e    state_r,   state_nx;
   logic [2:0]    bit_cnt_r, bit_cnt_nx;
   logic [7:0]    shreg_r,   shreg_nx;
   logic          parity_r,  parity_nx;
   logic [TW-1:0] to_cnt_r,  to_cnt_nx;
   logic          timeout_s;
   logic          accept_s;
   logic          perr_s;
   logic          ferr_s;

   logic [23:0]   data_r;
   logic [7:0]    byte_r;
   logic          valid_r;
   logic          perr_r;
   logic          ferr_r;
   logic          busy_r;

   assign timeout_s = (state_r != IDLE) && (to_cnt_r == TO_LAST);

   // Frame sequencing: advance only on a sample strobe; a strobe in the same
   // cycle as the timeout wins because it restarts the counter.
   always_comb begin
      state_nx   = state_r;
      bit_cnt_nx = bit_cnt_r;
      shreg_nx   = shreg_r;
      parity_nx  = parity_r;
      accept_s   = 1'b0;
      perr_s     = 1'b0;
      ferr_s     = 1'b0;
      if (sample_s) begin
         case (state_r)
            IDLE: begin
               if (d_level_s == PS2_START_BIT) begin
                  state_nx   = DATA;
                  bit_cnt_nx = 3'd0;
               end else begin
                  state_nx = IDLE;
               end
            end
            DATA: begin
               shreg_nx   = {d_level_s, shreg_r[7:1]};
               bit_cnt_nx = bit_cnt_r + 3'd1;
               if (bit_cnt_r == 3'(PS2_DATA_BITS - 1)) begin
                  state_nx = PARITY;
               end else begin
                  state_nx = DATA;
               end
            end
            PARITY: begin
               parity_nx = d_level_s;
               state_nx  = STOP;
            end
            STOP: begin
               state_nx = IDLE;
               if (d_level_s == PS2_STOP_BIT) begin
                  if (odd_parity_ok(shreg_r, parity_r)) begin
                     accept_s = 1'b1;
                  end else begin
                     perr_s = 1'b1;
                  end
               end else begin
                  ferr_s = 1'b1;
               end
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end else if (timeout_s) begin
         state_nx   = IDLE;
         bit_cnt_nx = 3'd0;
         shreg_nx   = 8'd0;
         ferr_s     = 1'b1;
      end else begin
         state_nx = state_r;
      end
   end

   // Inactivity counter: runs only mid-frame, restarts on every sample strobe.
   always_comb begin
      to_cnt_nx = to_cnt_r;
      if (sample_s || (state_r == IDLE)) begin
         to_cnt_nx = {TW{1'b0}};
      end else if (timeout_s) begin
         to_cnt_nx = {TW{1'b0}};
      end else begin
         to_cnt_nx = to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      end
   end

   // State, shift register and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r   <= IDLE;
         bit_cnt_r <= 3'd0;
         shreg_r   <= 8'd0;
         parity_r  <= 1'b0;
         to_cnt_r  <= {TW{1'b0}};
         data_r    <= 24'd0;
         byte_r    <= 8'd0;
         valid_r   <= 1'b0;
         perr_r    <= 1'b0;
         ferr_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nx;
         bit_cnt_r <= bit_cnt_nx;
         shreg_r   <= shreg_nx;
         parity_r  <= parity_nx;
         to_cnt_r  <= to_cnt_nx;
         valid_r   <= accept_s;
         perr_r    <= perr_s;
         ferr_r    <= ferr_s;
         busy_r    <= (state_nx != IDLE);
         if (accept_s) begin
            data_r <= {data_r[15:0], shreg_r};
            byte_r <= shreg_r;
         end else begin
            data_r <= data_r;
            byte_r <= byte_r;
         end
      end
   end

   assign o_Data      = data_r;
   assign o_Byte      = byte_r;
   assign o_Valid     = valid_r;
   assign o_ParityErr = perr_r;
   assign o_FrameErr  = ferr_r;
   assign o_Busy      = busy_r;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver with a scaled PS/2 clock
// (half period HALF system clocks) and a short timeout.
module tb_ps2_frame_receiver;

   localparam int HALF = 20;
   localparam int TO   = 100;
   localparam int FL   = 8;
   // Raw PS2C fall -> FSM edge: 2 synchronizer + FL filter samples + 1 strobe register.
   localparam int EDGE_LAT = 2 + FL + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        ps2c;
   logic        ps2d;
   logic [23:0] o_Data;
   logic [7:0]  o_Byte;
   logic        o_Valid, o_ParityErr, o_FrameErr, o_Busy;

   int cmp_cnt = 0;
   int err_cnt = 0;
   int valid_cnt = 0;
   int perr_cnt = 0;
   int ferr_cnt = 0;
   int multi_cnt = 0;

   ps2_frame_receiver #(
      .CLK_FREQ_HZ    (50000000),
      .FILTER_LEN     (FL),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_PS2C      (ps2c),
      .i_PS2D      (ps2d),
      .o_Data      (o_Data),
      .o_Byte      (o_Byte),
      .o_Valid     (o_Valid),
      .o_ParityErr (o_ParityErr),
      .o_FrameErr  (o_FrameErr),
      .o_Busy      (o_Busy)
   );

   always #5 clk = ~clk;

   // Pulse tally, sampled away from the active edge.
   always @(negedge clk) begin
      if (o_Valid)     valid_cnt <= valid_cnt + 1;
      if (o_ParityErr) perr_cnt  <= perr_cnt + 1;
      if (o_FrameErr)  ferr_cnt  <= ferr_cnt + 1;
      if ((int'(o_Valid) + int'(o_ParityErr) + int'(o_FrameErr)) > 1) multi_cnt <= multi_cnt + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b);
      @(posedge clk); #1; ps2d = b;
      repeat (HALF) @(posedge clk);
      #1; ps2c = 1'b0;
      repeat (HALF) @(posedge clk);
      #1; ps2c = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      send_bit(par);
      send_bit(stop);
      @(posedge clk); #1; ps2d = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
      repeat (4) @(posedge clk);
      #1; rst = 1'b0;
      @(posedge clk); #1;
      cmp_cnt++; if (o_Data !== 24'h000000) begin err_cnt++; $display("FAIL reset_data: got %h want %h", o_Data, 24'h000000); end
      cmp_cnt++; if (o_Byte !== 8'h00) begin err_cnt++; $display("FAIL reset_byte: got %h want %h", o_Byte, 8'h00); end
      cmp_cnt++; if ({o_Valid, o_ParityErr, o_FrameErr, o_Busy} !== 4'b0000) begin err_cnt++;
         $display("FAIL reset_flags: got %b want %b", {o_Valid, o_ParityErr, o_FrameErr, o_Busy}, 4'b0000); end
   endtask

   task automatic test_three_frames();
      int v0, p0, f0;
      v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'h1C, 1'b0, 1'b1);
      cmp_cnt++; if (o_Byte !== 8'h1C) begin err_cnt++; $display("FAIL frame1_byte: got %h want %h", o_Byte, 8'h1C); end
      send_frame(8'hF0, 1'b1, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1);
      cmp_cnt++; if (valid_cnt - v0 !== 3) begin err_cnt++; $display("FAIL three_valid: got %0d want %0d", valid_cnt - v0, 3); end
      cmp_cnt++; if ((perr_cnt - p0) + (ferr_cnt - f0) !== 0) begin err_cnt++;
         $display("FAIL three_errs: got %0d want %0d", (perr_cnt - p0) + (ferr_cnt - f0), 0); end
      cmp_cnt++; if (o_Data !== 24'h1CF01C) begin err_cnt++; $display("FAIL three_data: got %h want %h", o_Data, 24'h1CF01C); end
      cmp_cnt++; if (o_Byte !== 8'h1C) begin err_cnt++; $display("FAIL three_byte: got %h want %h", o_Byte, 8'h1C); end
      cmp_cnt++; if (o_Busy !== 1'b0) begin err_cnt++; $display("FAIL three_busy: got %b want %b", o_Busy, 1'b0); end
   endtask

   task automatic test_parity_err();
      int v0, p0, f0;
      v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'h1C, 1'b1, 1'b1);
      cmp_cnt++; if (perr_cnt - p0 !== 1) begin err_cnt++; $display("FAIL parity_perr: got %0d want %0d", perr_cnt - p0, 1); end
      cmp_cnt++; if ((valid_cnt - v0) + (ferr_cnt - f0) !== 0) begin err_cnt++;
         $display("FAIL parity_others: got %0d want %0d", (valid_cnt - v0) + (ferr_cnt - f0), 0); end
      cmp_cnt++; if (o_Data !== 24'h1CF01C) begin err_cnt++; $display("FAIL parity_data: got %h want %h", o_Data, 24'h1CF01C); end
   endtask

   task automatic test_glitch();
      int v0, p0, f0, busy_seen;
      v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt; busy_seen = 0;
      @(posedge clk); #1; ps2d = 1'b0; ps2c = 1'b0;
      repeat (3) @(posedge clk);
      #1; ps2c = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (o_Busy) busy_seen++;
      end
      ps2d = 1'b1;
      cmp_cnt++; if (busy_seen !== 0) begin err_cnt++; $display("FAIL glitch_busy: got %0d busy cycles want %0d", busy_seen, 0); end
      cmp_cnt++; if ((valid_cnt - v0) + (perr_cnt - p0) + (ferr_cnt - f0) !== 0) begin err_cnt++;
         $display("FAIL glitch_pulses: got %0d want %0d", (valid_cnt - v0) + (perr_cnt - p0) + (ferr_cnt - f0), 0); end
      cmp_cnt++; if (o_Data !== 24'h1CF01C) begin err_cnt++; $display("FAIL glitch_data: got %h want %h", o_Data, 24'h1CF01C); end
   endtask

   task automatic test_timeout();
      int v0, f0, n, hit;
      logic busy_mid, busy_hit;
      v0 = valid_cnt; f0 = ferr_cnt; n = 0; hit = -1; busy_mid = 1'b0; busy_hit = 1'b1;
      // start + low nibble of 0x29 (LSB first: 1,0,0,1); the last bit is driven by hand
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      @(posedge clk); #1; ps2d = 1'b1;
      repeat (HALF) @(posedge clk);
      #1; ps2c = 1'b0;
      for (int i = 0; i < TO + EDGE_LAT + 40; i++) begin
         @(posedge clk); #1;
         n++;
         if (n == HALF) begin ps2c = 1'b1; busy_mid = o_Busy; end
         if (o_FrameErr && (hit < 0)) begin hit = n; busy_hit = o_Busy; end
      end
      cmp_cnt++; if (busy_mid !== 1'b1) begin err_cnt++; $display("FAIL timeout_busy_mid: got %b want %b", busy_mid, 1'b1); end
      cmp_cnt++; if (hit !== TO + EDGE_LAT) begin err_cnt++; $display("FAIL timeout_latency: got %0d want %0d", hit, TO + EDGE_LAT); end
      cmp_cnt++; if (busy_hit !== 1'b0) begin err_cnt++; $display("FAIL timeout_busy_drop: got %b want %b", busy_hit, 1'b0); end
      cmp_cnt++; if (ferr_cnt - f0 !== 1) begin err_cnt++; $display("FAIL timeout_ferr_count: got %0d want %0d", ferr_cnt - f0, 1); end
      cmp_cnt++; if (valid_cnt - v0 !== 0) begin err_cnt++; $display("FAIL timeout_valid: got %0d want %0d", valid_cnt - v0, 0); end
      send_frame(8'h29, 1'b0, 1'b1);
      cmp_cnt++; if (o_Data[7:0] !== 8'h29) begin err_cnt++; $display("FAIL after_timeout_low: got %h want %h", o_Data[7:0], 8'h29); end
      cmp_cnt++; if (o_Data !== 24'hF01C29) begin err_cnt++; $display("FAIL after_timeout_data: got %h want %h", o_Data, 24'hF01C29); end
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      logic [7:0] b;
      b = 8'h1C;
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(b[i]);
      pulse_reset();
      #1;
      cmp_cnt++; if (o_Busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_busy: got %b want %b", o_Busy, 1'b0); end
      cmp_cnt++; if (o_Data !== 24'h000000) begin err_cnt++; $display("FAIL midrst_cleared: got %h want %h", o_Data, 24'h000000); end
      v0 = valid_cnt;
      send_frame(8'h32, 1'b0, 1'b1);
      cmp_cnt++; if (o_Data !== 24'h000032) begin err_cnt++; $display("FAIL midrst_data: got %h want %h", o_Data, 24'h000032); end
      cmp_cnt++; if (valid_cnt - v0 !== 1) begin err_cnt++; $display("FAIL midrst_valid: got %0d want %0d", valid_cnt - v0, 1); end
      cmp_cnt++; if (o_Byte !== 8'h32) begin err_cnt++; $display("FAIL midrst_byte: got %h want %h", o_Byte, 8'h32); end
   endtask

   task automatic test_stop_err();
      int v0, p0, f0;
      v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
      send_frame(8'h1C, 1'b0, 1'b0);
      cmp_cnt++; if (ferr_cnt - f0 !== 1) begin err_cnt++; $display("FAIL stop_ferr: got %0d want %0d", ferr_cnt - f0, 1); end
      cmp_cnt++; if (perr_cnt - p0 !== 0) begin err_cnt++; $display("FAIL stop_perr: got %0d want %0d", perr_cnt - p0, 0); end
      cmp_cnt++; if (valid_cnt - v0 !== 0) begin err_cnt++; $display("FAIL stop_valid: got %0d want %0d", valid_cnt - v0, 0); end
      cmp_cnt++; if (o_Data !== 24'h000032) begin err_cnt++; $display("FAIL stop_data: got %h want %h", o_Data, 24'h000032); end
   endtask

   task automatic test_exclusive();
      cmp_cnt++; if (multi_cnt !== 0) begin err_cnt++; $display("FAIL exclusive_pulses: got %0d overlapping cycles want %0d", multi_cnt, 0); end
   endtask

   initial begin
      test_reset();
      test_three_frames();
      test_parity_err();
      test_glitch();
      test_timeout();
      test_reset_mid_frame();
      test_stop_err();
      test_exclusive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
